// File: rtl/i2c_regbank.sv
// I2C register bank: byte-addressed RO/RW 16-bit registers behind a byte-level
// I2C controller, with staged writes committed on stop and coherent 16-bit reads.
module i2c_regbank #(
  parameter int N_RO = 8,
  parameter int N_RW = 8,
  parameter logic [16*N_RW-1:0] RW_INIT = {N_RW{16'h0000}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              data_vld,
  input  logic              r_w,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              stretch_on,
  input  logic [16*N_RO-1:0] ro_data,
  input  logic              lock,
  output logic [16*N_RW-1:0] rw_data,
  output logic [N_RW-1:0]   wr_strobe,
  output logic              wr_err
);

  if (N_RO + N_RW > 128 || N_RW < 1) begin : g_bad_cfg
    $error("i2c_regbank: N_RO+N_RW must be <= 128 and N_RW >= 1");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PTR   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  localparam logic [7:0] PMAX = 8'(2 * (N_RO + N_RW) - 1);

  logic [1:0]         state_q, state_d;
  logic [7:0]         ptr_q, ptr_d;
  logic [16*N_RW-1:0] stage_q, stage_d;
  logic [N_RW-1:0]    pend_q, pend_d;
  logic [16*N_RW-1:0] rw_q, rw_d;
  logic [N_RW-1:0]    strb_q, strb_d;
  logic               err_q, err_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         snap_q, snap_d;
  logic               snap_vld_q, snap_vld_d;
  logic [6:0]         snap_idx_q, snap_idx_d;

  logic [6:0]         idx;
  logic [7:0]         ptr_inc;
  logic [15:0]        word;
  logic               mapped;
  logic               is_rw;
  logic [N_RW-1:0]    rwsel;

  assign idx     = ptr_q[7:1];
  assign ptr_inc = (ptr_q == PMAX) ? 8'h00 : ptr_q + 8'd1;

  always_comb begin
    word   = 16'hFFFF;
    mapped = 1'b0;
    is_rw  = 1'b0;
    rwsel  = '0;
    for (int k = 0; k < N_RO; k++) begin
      if (idx == 7'(k)) begin
        word   = ro_data[16*k +: 16];
        mapped = 1'b1;
      end
    end
    // RW reads see committed values only, never the staging copy
    for (int k = 0; k < N_RW; k++) begin
      if (idx == 7'(N_RO + k)) begin
        word     = rw_q[16*k +: 16];
        mapped   = 1'b1;
        is_rw    = 1'b1;
        rwsel[k] = 1'b1;
      end
    end
  end

  assign stretch_on = (state_q == RDATA) & data_vld & ~start & ~stop;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    stage_d    = stage_q;
    pend_d     = pend_q;
    rw_d       = rw_q;
    strb_d     = '0;
    err_d      = 1'b0;
    tx_d       = tx_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    snap_idx_d = snap_idx_q;
    if (stop) begin
      state_d    = IDLE;
      snap_vld_d = 1'b0;
      for (int k = 0; k < N_RW; k++) begin
        if (pend_q[k]) rw_d[16*k +: 16] = stage_q[16*k +: 16];
      end
      // unpaired MSB bytes are dropped by resyncing staging
      stage_d = rw_d;
      strb_d  = pend_q;
      pend_d  = '0;
    end else if (start) begin
      state_d    = r_w ? RDATA : PTR;
      snap_vld_d = 1'b0;
    end else if (data_vld) begin
      case (state_q)
        PTR: begin
          ptr_d   = rx_byte;
          state_d = WDATA;
        end
        WDATA: begin
          if (is_rw && !lock) begin
            for (int k = 0; k < N_RW; k++) begin
              if (rwsel[k]) begin
                if (ptr_q[0]) begin
                  stage_d[16*k +: 8] = rx_byte;
                  pend_d[k]          = 1'b1;
                end else begin
                  stage_d[16*k+8 +: 8] = rx_byte;
                end
              end
            end
          end else begin
            err_d = 1'b1;
          end
          ptr_d = ptr_inc;
        end
        RDATA: begin
          ptr_d      = ptr_inc;
          snap_vld_d = 1'b0;
          if (!mapped) begin
            tx_d = 8'hFF;
          end else if (!ptr_q[0]) begin
            tx_d       = word[15:8];
            snap_d     = word[7:0];
            snap_vld_d = 1'b1;
            snap_idx_d = idx;
          end else if (snap_vld_q && snap_idx_q == idx) begin
            tx_d = snap_q;
          end else begin
            tx_d = word[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= 8'h00;
      stage_q    <= RW_INIT;
      pend_q     <= '0;
      rw_q       <= RW_INIT;
      strb_q     <= '0;
      err_q      <= 1'b0;
      tx_q       <= 8'hFF;
      snap_q     <= 8'h00;
      snap_vld_q <= 1'b0;
      snap_idx_q <= 7'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      stage_q    <= stage_d;
      pend_q     <= pend_d;
      rw_q       <= rw_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      tx_q       <= tx_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      snap_idx_q <= snap_idx_d;
    end
  end

  assign tx_byte   = tx_q;
  assign rw_data   = rw_q;
  assign wr_strobe = strb_q;
  assign wr_err    = err_q;

endmodule
